// File: rtl/wb_mux_ctrl_reg_if.sv
// Wishbone classic slave bus bundle for the motor-pin mux control register.
interface wb_mux_ctrl_reg_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] wb_adr_i;
    logic [DATA_WIDTH-1:0] wb_dat_i;
    logic [DATA_WIDTH-1:0] wb_dat_o;
    logic                  wb_we_i;
    logic                  wb_stb_i;
    logic                  wb_cyc_i;
    logic                  wb_ack_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i,
        input  wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_mux_ctrl_reg.sv
// Wishbone control register owning the motor-pin mux selection. Every change
// of the applied mux passes through a safe-idle guard interval.
// Optional watchdog (reverts the mux to RESET_VALUE when not kicked) is built
// only when MUX_CTRL_WDOG_EN is defined.
module wb_mux_ctrl_reg #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned MUX_WIDTH    = 8,
    parameter int unsigned RESET_VALUE  = 0,
    parameter int unsigned GUARD_CYCLES = 1000,
    parameter int unsigned WDOG_CYCLES  = 72000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    wb_mux_ctrl_reg_if.slave      wb,
    output logic [DATA_WIDTH-1:0] o_mux_req,
    output logic [MUX_WIDTH-1:0]  o_mux_active,
    output logic                  o_guard
);

    // A guard of 0 cycles is promoted to 1, so the reload value floors at 0.
    localparam int unsigned GUARD_LOAD = (GUARD_CYCLES > 1) ? GUARD_CYCLES - 1 : 0;
    localparam int unsigned GCNT_W     = (GUARD_LOAD > 1) ? $clog2(GUARD_LOAD + 1) : 1;
    localparam logic [MUX_WIDTH-1:0] MUX_RST = MUX_WIDTH'(RESET_VALUE);

    localparam logic [1:0] A_CTRL   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_KICK   = 2'd2;

    typedef enum logic {
        ST_ACTIVE = 1'b0,
        ST_GUARD  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [GCNT_W-1:0]       gcnt_q, gcnt_d;
    logic [MUX_WIDTH-1:0]    req_q, req_d;
    logic [MUX_WIDTH-1:0]    act_q, act_d;
    logic                    ack_q, ack_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic                    tripped_q;

    logic                    bus_req;
    logic                    ctrl_wr;
    logic                    status_wr;
    logic                    kick_wr;
    logic [MUX_WIDTH-1:0]    wr_mux;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    unused_bus;

`ifdef MUX_CTRL_WDOG_EN
    localparam int unsigned WD_LIMIT = (WDOG_CYCLES > 1) ? WDOG_CYCLES - 1 : 0;
    localparam int unsigned WD_W     = (WD_LIMIT > 1) ? $clog2(WD_LIMIT + 1) : 1;

    logic [WD_W-1:0] wd_q, wd_d;
    logic            trip_d;
`else
    assign tripped_q = 1'b0;
`endif

    // Bus request decode; ACK never asserts on two consecutive cycles.
    assign bus_req   = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
    assign ctrl_wr   = bus_req & wb.wb_we_i & (wb.wb_adr_i[3:2] == A_CTRL);
    assign status_wr = bus_req & wb.wb_we_i & (wb.wb_adr_i[3:2] == A_STATUS);
    assign kick_wr   = bus_req & wb.wb_we_i & (wb.wb_adr_i[3:2] == A_KICK);
    assign wr_mux    = wb.wb_dat_i[MUX_WIDTH-1:0];

    // Only address bits [3:2] and the low data bits carry meaning.
    assign unused_bus = ^{wb.wb_adr_i, wb.wb_dat_i, kick_wr, status_wr};

    assign o_mux_req    = DATA_WIDTH'(req_q);
    assign o_mux_active = act_q;
    assign o_guard      = (state_q == ST_GUARD);
    assign wb.wb_ack_o  = ack_q;
    assign wb.wb_dat_o  = dat_q;

    // Read data mux; undecoded bits read as zero.
    always_comb begin
        rdata = '0;
        case (wb.wb_adr_i[3:2])
            A_CTRL:   rdata = DATA_WIDTH'(req_q);
            A_STATUS: rdata = (DATA_WIDTH'(act_q) << 8) | DATA_WIDTH'({tripped_q, o_guard});
            default:  rdata = '0;
        endcase
    end

    // Next-state logic: bus response, guard FSM and optional watchdog.
    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        req_d   = req_q;
        act_d   = act_q;
        ack_d   = bus_req;
        dat_d   = bus_req ? rdata : '0;
`ifdef MUX_CTRL_WDOG_EN
        wd_d    = wd_q;
        trip_d  = tripped_q;
`endif

        case (state_q)
            ST_ACTIVE: begin
                if (ctrl_wr) begin
                    req_d = wr_mux;
                    if (wr_mux != act_q) begin
                        state_d = ST_GUARD;
                        gcnt_d  = GCNT_W'(GUARD_LOAD);
                    end
                end
            end
            ST_GUARD: begin
                // A write on the expiry edge restarts the guard instead.
                if (ctrl_wr) begin
                    req_d  = wr_mux;
                    gcnt_d = GCNT_W'(GUARD_LOAD);
                end else if (gcnt_q == '0) begin
                    act_d   = req_q;
                    state_d = ST_ACTIVE;
                end else begin
                    gcnt_d = gcnt_q - GCNT_W'(1);
                end
            end
            default: state_d = ST_ACTIVE;
        endcase

`ifdef MUX_CTRL_WDOG_EN
        if (status_wr && wb.wb_dat_i[1]) begin
            trip_d = 1'b0;
        end
        // Trip is evaluated last so it overrides the W1C clear.
        if (ctrl_wr || kick_wr || (req_q == MUX_RST)) begin
            wd_d = '0;
        end else if (wd_q == WD_W'(WD_LIMIT)) begin
            wd_d    = '0;
            req_d   = MUX_RST;
            trip_d  = 1'b1;
            state_d = ST_GUARD;
            gcnt_d  = GCNT_W'(GUARD_LOAD);
        end else begin
            wd_d = wd_q + WD_W'(1);
        end
`endif
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_ACTIVE;
            gcnt_q  <= '0;
            req_q   <= MUX_RST;
            act_q   <= MUX_RST;
            ack_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
            req_q   <= req_d;
            act_q   <= act_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
        end
    end

`ifdef MUX_CTRL_WDOG_EN
    // Watchdog counter and trip flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wd_q      <= '0;
            tripped_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            tripped_q <= trip_d;
        end
    end
`endif

endmodule

// File: tb/tb_wb_mux_ctrl_reg.sv
// Bench for wb_mux_ctrl_reg: directed steps then random bus traffic, every
// cycle compared against a timestamp-based reference model.
// Watchdog scenarios are included when MUX_CTRL_WDOG_EN is defined.
module tb_wb_mux_ctrl_reg;

    localparam int unsigned G  = 4;
    localparam int unsigned WD = 16;
    localparam logic [7:0]  RV = 8'h00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] mux_req;
    logic [7:0]  mux_active;
    logic        guard;

    wb_mux_ctrl_reg_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    wb_mux_ctrl_reg #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (32),
        .MUX_WIDTH    (8),
        .RESET_VALUE  (0),
        .GUARD_CYCLES (G),
        .WDOG_CYCLES  (WD)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .wb           (bus.slave),
        .o_mux_req    (mux_req),
        .o_mux_active (mux_active),
        .o_guard      (guard)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model: the guard is a deadline (edge number) rather than a counter.
    longint      n = 0;
    logic        m_ack;
    logic [31:0] m_dat;
    logic [7:0]  m_req;
    logic [7:0]  m_active;
    logic        m_pend;
    logic        m_trip;
    longint      m_gend;
    longint      m_wdbase;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic        rq, wc, ws, wk;
        logic [31:0] rd;
        logic [7:0]  v;
        logic [7:0]  pre_req;
        if (rst) begin
            m_ack = 1'b0; m_dat = '0; m_req = RV; m_active = RV;
            m_pend = 1'b0; m_trip = 1'b0; m_wdbase = n;
            return;
        end
        rq = bus.wb_stb_i & bus.wb_cyc_i & ~m_ack;
        case (bus.wb_adr_i[3:2])
            2'd0:    rd = {24'h0, m_req};
            2'd1:    rd = {16'h0, m_active, 6'h0, m_trip, m_pend};
            default: rd = '0;
        endcase
        wc = rq & bus.wb_we_i & (bus.wb_adr_i[3:2] == 2'd0);
        ws = rq & bus.wb_we_i & (bus.wb_adr_i[3:2] == 2'd1);
        wk = rq & bus.wb_we_i & (bus.wb_adr_i[3:2] == 2'd2);
        pre_req = m_req;
        m_dat = rq ? rd : '0;
        m_ack = rq;
        if (m_pend && !wc && n == m_gend) begin
            m_active = m_req;
            m_pend   = 1'b0;
        end
        if (wc) begin
            v = bus.wb_dat_i[7:0];
            if (m_pend || v != m_active) begin
                m_pend = 1'b1;
                m_gend = n + G;
            end
            m_req = v;
        end
`ifdef MUX_CTRL_WDOG_EN
        if (ws && bus.wb_dat_i[1]) m_trip = 1'b0;
        if (wc || wk || pre_req == RV) begin
            m_wdbase = n;
        end else if (n - m_wdbase == WD) begin
            m_req = RV; m_trip = 1'b1; m_pend = 1'b1; m_gend = n + G; m_wdbase = n;
        end
`else
        if (ws || wk) m_wdbase = n;
`endif
    endtask

    // One clock: advance model on the edge, compare all outputs just after it.
    task automatic tick();
        @(posedge clk);
        n++;
        model_edge();
        #1;
        chk("ack",        {31'h0, bus.wb_ack_o}, {31'h0, m_ack});
        chk("dat_o",      bus.wb_dat_o,          m_dat);
        chk("mux_req",    mux_req,               {24'h0, m_req});
        chk("mux_active", {24'h0, mux_active},   {24'h0, m_active});
        chk("guard",      {31'h0, guard},        {31'h0, m_pend});
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    task automatic wb(input logic we, input logic [31:0] a, input logic [31:0] d);
        bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
        bus.wb_adr_i = a;    bus.wb_dat_i = d;
        tick();
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        tick();
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] a, d;
        bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
        bus.wb_adr_i = '0;   bus.wb_dat_i = '0;
        m_ack = 1'b0; m_dat = '0; m_req = RV; m_active = RV;
        m_pend = 1'b0; m_trip = 1'b0; m_gend = 0; m_wdbase = 0;

        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);

        // Reset state readback.
        wb(1'b0, 32'h0, 32'h0);
        wb(1'b0, 32'h4, 32'h0);

        // Single change with a STATUS read inside the guard.
        wb(1'b1, 32'h0, 32'h05);
        wb(1'b0, 32'h4, 32'h0);
        idle(4);
        wb(1'b0, 32'h4, 32'h0);

        // Back-to-back changes restart the guard; 5 is never applied.
        pulse_rst();
        wb(1'b1, 32'h0, 32'h05);
        wb(1'b1, 32'h0, 32'h03);
        idle(6);

        // Masking, same-value write, reserved and KICK addresses.
        wb(1'b1, 32'h0, 32'h1FF);
        idle(6);
        wb(1'b0, 32'h0, 32'h0);
        wb(1'b1, 32'h0, 32'hFF);
        idle(2);
        wb(1'b1, 32'hC, 32'hDEAD_BEEF);
        wb(1'b0, 32'hC, 32'h0);
        wb(1'b1, 32'h8, 32'h0);
        wb(1'b0, 32'h8, 32'h0);

        // Reset in the middle of a guard.
        wb(1'b1, 32'h0, 32'h11);
        pulse_rst();
        wb(1'b0, 32'h0, 32'h0);
        wb(1'b0, 32'h4, 32'h0);

`ifdef MUX_CTRL_WDOG_EN
        // Watchdog trip, W1C clear, then kicking keeps it quiet.
        wb(1'b1, 32'h0, 32'h02);
        idle(30);
        wb(1'b0, 32'h4, 32'h0);
        wb(1'b1, 32'h4, 32'h2);
        wb(1'b0, 32'h4, 32'h0);
        wb(1'b1, 32'h0, 32'h02);
        for (int k = 0; k < 5; k++) begin
            idle(8);
            wb(1'b1, 32'h8, 32'h0);
        end
        wb(1'b0, 32'h4, 32'h0);
`else
        // Without the watchdog KICK and W1C writes change nothing.
        wb(1'b1, 32'h0, 32'h02);
        idle(30);
        wb(1'b1, 32'h4, 32'h2);
        wb(1'b0, 32'h4, 32'h0);
`endif

        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            a = $urandom;
            a[3:2] = ($urandom_range(0, 3) == 0) ? 2'(a[3:2]) : 2'd0;
            d = $urandom;
            d[7:0] = 8'($urandom_range(0, 3));
            bus.wb_adr_i = a;
            bus.wb_dat_i = d;
            bus.wb_we_i  = 1'($urandom_range(0, 1));
            bus.wb_stb_i = ($urandom_range(0, 9) < 3);
            bus.wb_cyc_i = ($urandom_range(0, 9) < 8);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        bus.wb_stb_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_we_i = 1'b0;
        idle(10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
